// File: rtl/arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : arb_pkg                                                  |
// | Shared mode constants and state encoding for prio_arbiter.         |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package arb_pkg;

  // Arbitration mode, sampled only when an arbitration happens
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Arbiter ownership state
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/prio_arbiter_pick_hi.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : pick_hi                                                  |
// | Combinational priority encoder: index of the highest set bit of    |
// | an N-bit vector plus a flag telling whether any bit is set.        |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module pick_hi #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)   // derived from N; do not override
) (
  input  logic [N-1:0]  in,
  output logic [IW-1:0] idx,
  output logic          v
);

  // Ascending scan: the last set bit seen is the highest one
  always_comb begin
    idx = '0;
    v   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in[i]) begin
        idx = IW'(i);
        v   = 1'b1;
      end
    end
  end

endmodule : pick_hi
`default_nettype wire

// File: rtl/prio_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : prio_arbiter                                             |
// | Registered N-channel arbiter, fixed-priority (highest index wins)  |
// | or round-robin selected at runtime. A grant is held until its      |
// | owner drops the request; the next owner follows with no gap.       |
// | Optional: ARB_TIMEOUT_EN forces re-arbitration after MAX_HOLD      |
// | consecutive owned cycles when another channel is waiting.          |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module prio_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int IW       = $clog2(N),  // derived from N; do not override
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          mode,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          valid
);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] last_q,  last_d;

  logic          hold_expired;
  logic          owner_req;
  logic          others_req;
  logic          do_arb;
  logic [N-1:0]  arb_vec;
  logic [N-1:0]  rr_mask;
  logic [IW-1:0] m_idx, u_idx;
  logic          m_v,   u_v;
  logic [IW-1:0] win_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD) + 1;
  logic [CW-1:0] cnt_q, cnt_d;

  // Owner has used up its hold budget on this edge
  always_comb begin
    hold_expired = (state_q == OWNED) && (cnt_q == CW'(MAX_HOLD - 1));
  end
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;

  // Without the timeout the owner keeps the grant for as long as it requests
  always_comb begin
    hold_expired = 1'b0;
  end
`endif

  // Decide whether this edge arbitrates and which requests take part
  always_comb begin
    owner_req  = req[idx_q];
    others_req = |(req & ~grant_q);
    if (state_q == IDLE) begin
      do_arb = |req;
    end else begin
      do_arb = !owner_req || (hold_expired && others_req);
    end
    // Masking the owner is a no-op when it has dropped its request and
    // is exactly what a forced re-arbitration needs.
    arb_vec = (state_q == OWNED) ? (req & ~grant_q) : req;
    // Round-robin searches below the last owner first, then wraps
    for (int i = 0; i < N; i++) begin
      rr_mask[i] = (i < int'(last_q));
    end
  end

  pick_hi #(.N(N), .IW(IW)) u_pick_masked (
    .in  (arb_vec & rr_mask),
    .idx (m_idx),
    .v   (m_v)
  );

  pick_hi #(.N(N), .IW(IW)) u_pick_full (
    .in  (arb_vec),
    .idx (u_idx),
    .v   (u_v)
  );

  // Next-state and next-output computation
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    win_idx = (mode == MODE_RR && m_v) ? m_idx : u_idx;

    if (do_arb) begin
`ifdef ARB_TIMEOUT_EN
      cnt_d = '0;
`endif
      if (u_v) begin
        state_d = OWNED;
        grant_d = N'(1) << win_idx;
        idx_d   = win_idx;
        valid_d = 1'b1;
        last_d  = win_idx;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    end else if (state_q == OWNED) begin
`ifdef ARB_TIMEOUT_EN
      // Budget spent but nobody else waiting: keep the grant, restart the count
      cnt_d = hold_expired ? '0 : cnt_q + CW'(1);
`endif
    end
  end

  // State and registered outputs; reset clears them asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign valid     = valid_q;

endmodule : prio_arbiter
`default_nettype wire

// File: tb/tb_prio_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_prio_arbiter                                          |
// | Self-checking bench for prio_arbiter (N=4): directed scenarios     |
// | plus randomized traffic against a behavioural ownership model.     |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_prio_arbiter;

  localparam int N        = 4;
  localparam int IW       = 2;
  localparam int MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          mode = 1'b0;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner (-1 = none), last owner, owned-cycle count
  int m_owner = -1;
  int m_last  = 0;
  int m_cnt   = 0;

  prio_arbiter #(.N(N), .IW(IW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  function automatic int model_pick(input logic [N-1:0] v, input logic md);
    if (md == 1'b0) begin
      for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last - k + N) % N;
        if (v[c]) return c;
      end
    end
    return -1;
  endfunction

  task automatic model_grant(input logic [N-1:0] v, input logic md);
    int w;
    w = model_pick(v, md);
    m_owner = w;
    m_cnt   = 0;
    if (w >= 0) m_last = w;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_cnt   = 0;
  endtask

  // Behaviour at one rising edge given the inputs present at that edge
  task automatic model_step(input logic [N-1:0] r, input logic md);
    if (m_owner < 0) begin
      if (r != 0) model_grant(r, md);
    end else if (!r[m_owner]) begin
      model_grant(r, md);
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_cnt == MAX_HOLD - 1) begin
        logic [N-1:0] others;
        others = r;
        others[m_owner] = 1'b0;
        if (others != 0) model_grant(others, md);
        else m_cnt = 0;
      end else begin
        m_cnt++;
      end
`else
      m_cnt++;
`endif
    end
  endtask

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  // One clock edge; model follows the same inputs; return #1 after the edge
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step(req, mode);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    #3;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (grant !== 4'b0000 || valid !== 1'b0 || grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_hold: grant=%b idx=%0d valid=%b required 0000/0/0", grant, grant_idx, valid);
    end
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (grant !== 4'b0000 || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset[%0d]: grant=%b valid=%b required 0000/0", i, grant, valid);
      end
    end
  endtask

  task automatic test_fixed_latency();
    mode = 1'b0;
    req  = 4'b0101;
    tick();
    n_checks++;
    if (grant !== 4'b0100 || grant_idx !== 2'd2 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fixed_latency: grant=%b idx=%0d valid=%b required 0100/2/1", grant, grant_idx, valid);
    end
    req = 4'b1101;
    tick();
    n_checks++;
    if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL no_preempt: grant=%b idx=%0d required 0100/2", grant, grant_idx);
    end
  endtask

  task automatic test_handover();
    req = 4'b1011;
    tick();
    n_checks++;
    if (grant !== 4'b1000 || grant_idx !== 2'd3 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL handover: grant=%b idx=%0d valid=%b required 1000/3/1", grant, grant_idx, valid);
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (valid !== 1'b0 || grant !== 4'b0000 || grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL release_idle: grant=%b idx=%0d valid=%b required 0000/0/0", grant, grant_idx, valid);
    end
  endtask

  task automatic test_rr_fairness();
    int exp_seq[5] = '{3, 2, 1, 0, 3};
    logic [N-1:0] r;
    do_reset();
    mode = 1'b1;
    req  = 4'b1111;
    tick();
    for (int s = 0; s < 5; s++) begin
      n_checks++;
      if (grant_idx !== exp_seq[s][IW-1:0] || valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: idx=%0d valid=%b required %0d/1", s, grant_idx, valid, exp_seq[s]);
      end
      r = 4'b1111;
      r[grant_idx] = 1'b0;
      req = r;
      tick();
    end
    req = '0;
    tick();
  endtask

  task automatic test_async_reset();
    mode = 1'b0;
    req  = 4'b0010;
    tick();
    n_checks++;
    if (grant_idx !== 2'd1 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_owner: idx=%0d valid=%b required 1/1", grant_idx, valid);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (grant !== 4'b0000 || valid !== 1'b0 || grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL async_clear: grant=%b idx=%0d valid=%b required 0000/0/0", grant, grant_idx, valid);
    end
    #1;
    rst = 1'b0;
    tick();
    n_checks++;
    if (grant !== 4'b0010 || grant_idx !== 2'd1 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_grant: grant=%b idx=%0d valid=%b required 0010/1/1", grant, grant_idx, valid);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mode = 1'b0;
    req  = 4'b0011;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (grant_idx !== 2'd1 || valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_before_timeout[%0d]: idx=%0d required 1", i, grant_idx);
      end
      tick();
    end
    n_checks++;
    if (grant_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL hold_last_cycle: idx=%0d required 1", grant_idx);
    end
    tick();
    n_checks++;
    if (grant_idx !== 2'd0 || grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL timeout_move: grant=%b idx=%0d required 0001/0", grant, grant_idx);
    end
    req = 4'b0010;
    tick();
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (grant_idx !== 2'd1 || valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_indefinite[%0d]: idx=%0d valid=%b required 1/1", i, grant_idx, valid);
      end
    end
    req = 4'b0010;
`endif
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (grant !== 4'b0010 || grant_idx !== 2'd1 || valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sole_owner_hold[%0d]: grant=%b idx=%0d required 0010/1", i, grant, grant_idx);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    logic [N-1:0] r;
    for (int c = 0; c < 400; c++) begin
      r = N'($urandom_range(0, 15));
      // Bias towards holding so that long ownerships and timeouts occur
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      req  = r;
      mode = 1'($urandom_range(0, 1));
      tick();
      eg = exp_grant();
      n_checks++;
      if (grant !== eg || valid !== (m_owner >= 0) ||
          grant_idx !== ((m_owner >= 0) ? IW'(m_owner) : 2'd0)) begin
        n_fail++;
        $display("FAIL random[%0d]: grant=%b idx=%0d valid=%b required grant=%b owner=%0d",
                 c, grant, grant_idx, valid, eg, m_owner);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_latency();
    test_handover();
    test_rr_fairness();
    test_async_reset();
    test_timeout();
    do_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_prio_arbiter
`default_nettype wire
